// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential IEEE-754 single-precision divider (restoring, 1 quotient bit/cycle)
module fp_div_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        done,
   output logic        busy,
   output logic        invalid,
   output logic        div_by_zero,
   output logic        overflow,
   output logic        underflow
);
   typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, NORM, DONE} state_t;

   state_t             state, state_nx;
   logic [31:0]        a_q, b_q;
   logic               sign;
   logic [23:0]        mb;
   logic [25:0]        rem;
   logic [25:0]        q;
   logic signed [9:0]  exp_q;
   logic [4:0]         cnt;

   // operand classification; exponent-0 operands are flushed to zero
   logic [7:0] ea, eb;
   logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic       special;
   logic [31:0] spec_res;
   logic       spec_inv, spec_dbz;

   assign ea     = a_q[30:23];
   assign eb     = b_q[30:23];
   assign a_zero = (ea == 8'd0);
   assign b_zero = (eb == 8'd0);
   assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
   assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
   assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
   assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);

   always_comb begin
      special  = 1'b1;
      spec_res = 32'd0;
      spec_inv = 1'b0;
      spec_dbz = 1'b0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_res = 32'h7FC00000;
         spec_inv = 1'b1;
      end else if (a_inf) begin
         spec_res = {a_q[31] ^ b_q[31], 31'h7F800000};
      end else if (b_zero) begin
         spec_res = {a_q[31] ^ b_q[31], 31'h7F800000};
         spec_dbz = 1'b1;
      end else if (a_zero || b_inf) begin
         spec_res = {a_q[31] ^ b_q[31], 31'd0};
      end else begin
         special = 1'b0;
      end
   end

   // restoring step
   logic [25:0] diff;
   logic        ge;
   assign diff = rem - {2'b00, mb};
   assign ge   = (rem >= {2'b00, mb});

   // normalise and round-to-nearest-even; the hidden bit is always set, so a
   // carry out of the 23-bit fraction means the mantissa reached 0x1000000
   logic [22:0]       n_frac, frac_out;
   logic              n_g, n_s, inc, carry;
   logic signed [9:0] n_exp, exp_out;

   always_comb begin
      if (q[25]) begin
         n_frac = q[24:2];
         n_g    = q[1];
         n_s    = q[0] | (rem != 26'd0);
         n_exp  = exp_q;
      end else begin
         n_frac = q[23:1];
         n_g    = q[0];
         n_s    = (rem != 26'd0);
         n_exp  = exp_q - 10'sd1;
      end
      inc               = n_g & (n_s | n_frac[0]);
      {carry, frac_out} = {1'b0, n_frac} + {23'd0, inc};
      exp_out           = carry ? n_exp + 10'sd1 : n_exp;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CHECK;
         CHECK:   state_nx = special ? DONE : DIVIDE;
         DIVIDE:  if (cnt == 5'd25) state_nx = NORM;
         NORM:    state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign done = (state == DONE);
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         sign        <= 1'b0;
         mb          <= 24'd0;
         rem         <= 26'd0;
         q           <= 26'd0;
         exp_q       <= 10'sd0;
         cnt         <= 5'd0;
         result      <= 32'd0;
         invalid     <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (start) begin
               a_q         <= a;
               b_q         <= b;
               invalid     <= 1'b0;
               div_by_zero <= 1'b0;
               overflow    <= 1'b0;
               underflow   <= 1'b0;
            end
            CHECK: begin
               sign <= a_q[31] ^ b_q[31];
               if (special) begin
                  result      <= spec_res;
                  invalid     <= spec_inv;
                  div_by_zero <= spec_dbz;
               end else begin
                  mb    <= {1'b1, b_q[22:0]};
                  rem   <= {3'b000, a_q[22:0]} | 26'h0800000;
                  q     <= 26'd0;
                  cnt   <= 5'd0;
                  exp_q <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
               end
            end
            DIVIDE: begin
               q   <= {q[24:0], ge};
               rem <= ge ? {diff[24:0], 1'b0} : {rem[24:0], 1'b0};
               cnt <= cnt + 5'd1;
            end
            NORM: begin
               if (exp_out >= 10'sd255) begin
                  result   <= {sign, 31'h7F800000};
                  overflow <= 1'b1;
               end else if (exp_out <= 10'sd0) begin
                  result    <= {sign, 31'd0};
                  underflow <= 1'b1;
               end else begin
                  result <= {sign, exp_out[7:0], frac_out};
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - directed self-checking bench for fp_div_seq
module tb_fp_div_seq;
   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] a, b;
   logic [31:0] result;
   logic        done, busy, invalid, div_by_zero, overflow, underflow;
   int          checks = 0;
   int          errors = 0;
   int          n;
   logic        seen_done;

   fp_div_seq dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .result(result), .done(done), .busy(busy), .invalid(invalid),
      .div_by_zero(div_by_zero), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // launch with start held one cycle; n = cycle number in which done is seen
   task automatic launch(input logic [31:0] va, input logic [31:0] vb);
      @(negedge clk);
      a = va; b = vb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
   endtask

   task automatic wait_done();
      while (!done && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] exp_res, input logic [3:0] exp_flags, input int exp_lat);
      launch(va, vb);
      wait_done();
      chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_flags"}, {28'd0, invalid, div_by_zero, overflow, underflow}, {28'd0, exp_flags});
      @(posedge clk); #1;
      chk({tag, "_idle"}, {30'd0, done, busy}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; a = 32'h40C00000; b = 32'h40000000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out", result, 32'd0);
      chk("reset_ctl", {26'd0, done, busy, invalid, div_by_zero, overflow, underflow}, 32'd0);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      run("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29);
      run("one_third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29);
      run("div_zero",   32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2);
      run("zero_zero",  32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2);
      run("ovf",        32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 29);
      run("unf",        32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 29);
      run("neg",        32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000, 29);
      run("no_carry",   32'h3F7FFFFF, 32'h3F800000, 32'h3F7FFFFF, 4'b0000, 29);
      run("nan",        32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2);
      run("inf_inf",    32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 2);
      run("inf_fin",    32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2);
      run("fin_inf",    32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 2);
      run("denorm_num", 32'h00400000, 32'h40000000, 32'h00000000, 4'b0000, 2);

      // start pulsed during DIVIDE cycle 5 must not disturb the running divide
      launch(32'h40C00000, 32'h40000000);
      while (n < 6) begin @(posedge clk); #1; n++; end
      a = 32'h3F800000; b = 32'h00000000; start = 1'b1;
      @(posedge clk); #1; n++;
      start = 1'b0;
      wait_done();
      chk("ign_lat", 32'(n), 32'd29);
      chk("ign_res", result, 32'h40400000);
      chk("ign_flags", {28'd0, invalid, div_by_zero, overflow, underflow}, 32'd0);
      @(posedge clk); #1;

      // reset during DIVIDE cycle 10 aborts with no done pulse
      launch(32'h3F800000, 32'h40400000);
      while (n < 11) begin @(posedge clk); #1; n++; end
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_ctl", {30'd0, done, busy}, 32'd0);
      chk("abort_res", result, 32'd0);
      reset = 1'b0;
      seen_done = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         seen_done = seen_done | done;
      end
      chk("abort_nodone", {31'd0, seen_done}, 32'd0);

      // start held high across DONE: ignored in DONE cycle, accepted in the following IDLE
      @(negedge clk);
      a = 32'h3F800000; b = 32'h00000000; start = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("hold_done", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      chk("hold_idle", {30'd0, done, busy}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_accept", {31'd0, busy}, 32'd1);
      n = 1;
      wait_done();
      chk("hold_lat", 32'(n), 32'd2);
      chk("hold_res", result, 32'h7F800000);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high; sampled only on the rising edge of clk.
REQ-003 SHALL have port start, input, 1, request to divide; sampled only in IDLE.
REQ-004 SHALL have port a, input, 32, IEEE-754 single-precision dividend.
REQ-005 SHALL have port b, input, 32, IEEE-754 single-precision divisor.
REQ-006 SHALL have port result, output, 32, IEEE-754 single-precision quotient.
REQ-007 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have ports invalid, div_by_zero, overflow, underflow, output, 1 each, exception flags.

Function
REQ-010 SHALL implement FSM states IDLE, CHECK, DIVIDE, NORM, DONE.
REQ-011 IDLE with start=1 SHALL capture a and b, clear all flags, and go to CHECK.
REQ-012 start in any state other than IDLE SHALL be ignored, with no effect on the operation in progress.
REQ-013 CHECK SHALL compute sign = a[31]^b[31] and treat exponent-0 operands (zero or denormal) as zero, flushing denormals.
REQ-014 CHECK SHALL resolve special cases and go to DONE:
- NaN operand, 0/0, or inf/inf -> 0x7FC00000, invalid=1.
- finite nonzero/0 -> signed inf, div_by_zero=1.
- inf/finite -> signed inf.
- 0/finite nonzero or finite/inf -> signed zero.
REQ-015 Otherwise, CHECK SHALL load ma={1,a[22:0]}, mb={1,b[22:0]}, 26-bit remainder R=ma, exp = ea-eb+127 as 10-bit signed, and go to DIVIDE.
REQ-016 DIVIDE SHALL perform restoring division, one quotient bit per cycle for exactly 26 cycles, counted by a 5-bit counter:
- if R>=mb: q bit=1, R=R-mb; else q bit=0.
- then R=R<<1.
- bits fill q[25] down to q[0].
REQ-017 NORM SHALL normalise and round:
- if q[25]=1: mant=q[25:2], guard=q[1], sticky=q[0]|(R!=0).
- else: mant=q[24:1], guard=q[0], sticky=(R!=0), exp=exp-1.
- round to nearest even: increment when guard & (sticky | mant[0]).
- a rounding carry to 0x1000000 SHALL set mant=0x800000 and exp=exp+1.
REQ-018 NORM range check:
- exp>=255 -> signed inf (0x7F800000|sign<<31), overflow=1.
- exp<=0 -> signed zero, underflow=1.
- otherwise result={sign, exp[7:0], mant[22:0]}.
REQ-019 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-020 Latency, measured from the edge that samples start:
- normal path: done high in cycle 29.
- special-case path: done high in cycle 2.
REQ-021 result and flags SHALL update only on entry to DONE and hold until the next accepted start.
REQ-022 A start asserted in the same cycle that DONE returns to IDLE SHALL NOT be accepted; it is accepted on the following cycle if still high.

Reset
REQ-023 reset=1 SHALL force IDLE and set result=0, done=0, busy=0 and all flags=0, taking priority over start.
REQ-024 reset asserted mid-DIVIDE or mid-NORM SHALL abort the operation, with no done pulse.
REQ-025 After reset deasserts, the block SHALL accept start on the first IDLE cycle.

Verification
REQ-026 a=0x40C00000 (6.0), b=0x40000000 (2.0) -> result=0x40400000, done at cycle 29, no flags.
REQ-027 a=0x3F800000, b=0x40400000 (1/3) -> result=0x3EAAAAAB (round-up path), no flags.
REQ-028 a=0x3F800000, b=0x00000000 -> result=0x7F800000, div_by_zero=1, done at cycle 2; a=b=0 -> 0x7FC00000, invalid=1.
REQ-029 a=0x7F7FFFFF, b=0x3F000000 -> 0x7F800000, overflow=1; a=0x00800000, b=0x40000000 -> 0x00000000, underflow=1.
REQ-030 start pulsed again at DIVIDE cycle 5 -> ignored, first result delivered unchanged; reset at DIVIDE cycle 10 -> busy=0 next cycle, no done, outputs zero.
REQ-031 a=0xBF800000, b=0x3F800000 -> 0xBF800000 (sign path); a=0x3F7FFFFF, b=0x3F800000 -> 0x3F7FFFFF (no spurious carry).
